// File: rtl/compressor_tree_pipe_pkg.sv
// Shared sizing helpers for the pipelined 3:1 compressor tree.
package compressor_tree_pipe_pkg;

  // Largest term count the tree is sized for (five levels of 3:1 reduction).
  localparam int unsigned MAX_ELEMENTS = 243;

  // Number of words one level produces from n inputs: ceil(n/3).
  function automatic int unsigned level_width(input int unsigned n);
    return (n + 2) / 3;
  endfunction

  // Number of ceil-by-3 levels needed to bring n terms down to one word.
  function automatic int unsigned num_levels(input int unsigned n);
    int unsigned m;
    int unsigned l;
    m = n;
    l = 0;
    while (m > 1) begin
      m = level_width(m);
      l++;
    end
    return l;
  endfunction

  // Number of words entering level lvl when the tree starts with n terms.
  function automatic int unsigned level_inputs(input int unsigned n, input int unsigned lvl);
    int unsigned m;
    m = n;
    for (int unsigned i = 0; i < lvl; i++) begin
      m = level_width(m);
    end
    return m;
  endfunction

endpackage

// File: rtl/compressor_tree_pipe_level.sv
// One combinational reduction level: triples in index order are compressed
// 3:1 with a carry-save step and a final add; a leftover pair is added and a
// leftover single word passes through, always landing in the last output slot.
module compressor_3_to_1_tree_level
  import compressor_tree_pipe_pkg::*;
#(
  parameter int unsigned NUM_ELEMENTS = 3,
  parameter int unsigned BIT_LEN      = 8,
  localparam int unsigned NUM_OUT     = level_width(NUM_ELEMENTS)
) (
  input  logic [BIT_LEN-1:0] in_terms  [NUM_ELEMENTS],
  output logic [BIT_LEN-1:0] out_terms [NUM_OUT]
);

  localparam int unsigned NUM_TRIPLES = NUM_ELEMENTS / 3;
  localparam int unsigned REMAINDER   = NUM_ELEMENTS % 3;

  for (genvar g = 0; g < NUM_TRIPLES; g++) begin : g_triple
    logic [BIT_LEN-1:0] a;
    logic [BIT_LEN-1:0] b;
    logic [BIT_LEN-1:0] c;
    logic [BIT_LEN-1:0] sum_bits;

    assign a        = in_terms[3*g];
    assign b        = in_terms[3*g+1];
    assign c        = in_terms[3*g+2];
    assign sum_bits = a ^ b ^ c;
    // Majority bits are the carries; shifting left drops the top carry (mod 2^BIT_LEN).
    assign out_terms[g] = sum_bits + (((a & b) | (a & c) | (b & c)) << 1);
  end

  if (REMAINDER == 2) begin : g_rem_pair
    assign out_terms[NUM_OUT-1] = in_terms[NUM_ELEMENTS-2] + in_terms[NUM_ELEMENTS-1];
  end else if (REMAINDER == 1) begin : g_rem_single
    assign out_terms[NUM_OUT-1] = in_terms[NUM_ELEMENTS-1];
  end

endmodule

// File: rtl/compressor_tree_pipe.sv
// Pipelined multi-operand adder: NUM_LEVELS 3:1 reduction levels, each
// followed by a register stage with its own valid bit. Stalls collapse
// bubbles: a stage loads whenever it is empty or its content moves on.
module compressor_tree_pipe
  import compressor_tree_pipe_pkg::*;
#(
  parameter int unsigned NUM_ELEMENTS = 21,
  parameter int unsigned BIT_LEN      = 58,
  localparam int unsigned NUM_LEVELS  = num_levels(NUM_ELEMENTS),
  localparam int unsigned IFW         = $clog2(NUM_LEVELS + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [BIT_LEN-1:0] terms [NUM_ELEMENTS],
  output logic               out_valid,
  input  logic               out_ready,
  output logic [BIT_LEN-1:0] result,
  output logic [IFW-1:0]     in_flight
);

  logic [NUM_LEVELS-1:0] stage_valid;
  logic [NUM_LEVELS-1:0] stage_load;
  logic [NUM_LEVELS-1:0] stage_adv;
  logic [NUM_LEVELS-1:0] src_valid;

  // Stall control, resolved from the output end backwards so each stage sees
  // whether its successor frees up this cycle.
  always_comb begin
    stage_adv  = '0;
    stage_load = '0;
    src_valid  = '0;
    for (int unsigned j = 0; j < NUM_LEVELS; j++) begin
      if (j == 0) begin
        stage_adv[NUM_LEVELS-1-j] = stage_valid[NUM_LEVELS-1-j] & out_ready;
      end else begin
        stage_adv[NUM_LEVELS-1-j] = stage_valid[NUM_LEVELS-1-j] & stage_load[NUM_LEVELS-j];
      end
      stage_load[NUM_LEVELS-1-j] = ~stage_valid[NUM_LEVELS-1-j] | stage_adv[NUM_LEVELS-1-j];
    end
    for (int unsigned k = 0; k < NUM_LEVELS; k++) begin
      if (k == 0) begin
        src_valid[k] = in_valid;
      end else begin
        src_valid[k] = stage_valid[k-1];
      end
    end
  end

  // Stage valid bits; reset discards everything in flight immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stage_valid <= '0;
    end else begin
      for (int unsigned k = 0; k < NUM_LEVELS; k++) begin
        if (stage_load[k]) begin
          stage_valid[k] <= src_valid[k];
        end
      end
    end
  end

  for (genvar k = 0; k < NUM_LEVELS; k++) begin : g_lvl
    localparam int unsigned W_IN  = level_inputs(NUM_ELEMENTS, k);
    localparam int unsigned W_OUT = level_width(W_IN);

    logic [BIT_LEN-1:0] d_in   [W_IN];
    logic [BIT_LEN-1:0] d_comb [W_OUT];
    logic [BIT_LEN-1:0] q      [W_OUT];

    if (k == 0) begin : g_src_in
      assign d_in = terms;
    end else begin : g_src_stage
      assign d_in = g_lvl[k-1].q;
    end

    compressor_3_to_1_tree_level #(
      .NUM_ELEMENTS (W_IN),
      .BIT_LEN      (BIT_LEN)
    ) u_level (
      .in_terms  (d_in),
      .out_terms (d_comb)
    );

    // Data only moves on a real transfer into this stage; no reset needed.
    always_ff @(posedge clk) begin
      if (stage_load[k] & src_valid[k]) begin
        q <= d_comb;
      end
    end
  end

  assign in_ready  = stage_load[0];
  assign out_valid = stage_valid[NUM_LEVELS-1];
  assign result    = g_lvl[NUM_LEVELS-1].q[0];

  // Occupancy count follows the valid bits directly.
  always_comb begin
    in_flight = '0;
    for (int unsigned k = 0; k < NUM_LEVELS; k++) begin
      in_flight = in_flight + IFW'(stage_valid[k]);
    end
  end

endmodule

// File: tb/tb_compressor_tree_pipe.sv
// Scoreboard bench for compressor_tree_pipe (21x58 instance plus a 2x8 instance).
module tb_compressor_tree_pipe;

  localparam int unsigned N = 21;
  localparam int unsigned W = 58;
  localparam int unsigned L = 3;

  typedef logic [W-1:0] word_t;
  typedef struct {
    word_t       val;
    int unsigned cyc;
    bit          lat;
  } exp_t;
  typedef struct {
    logic [7:0]  val;
    int unsigned cyc;
  } sexp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  word_t       terms [N];
  logic        out_valid;
  logic        out_ready = 1'b1;
  word_t       result;
  logic [1:0]  in_flight;

  logic        s_in_valid;
  logic        s_in_ready;
  logic [7:0]  s_terms [2];
  logic        s_out_valid;
  logic        s_out_ready;
  logic [7:0]  s_result;
  logic        s_in_flight;

  int unsigned cyc = 0;
  int          checks = 0;
  int          errors = 0;
  int          mode = 0;  // 0: out_ready high, 1: toggle, 2: low
  exp_t        sb [$];
  sexp_t       s_sb [$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    case (mode)
      0:       out_ready <= 1'b1;
      1:       out_ready <= ~out_ready;
      default: out_ready <= 1'b0;
    endcase
  end

  compressor_tree_pipe #(.NUM_ELEMENTS(N), .BIT_LEN(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .terms(terms),
    .out_valid(out_valid), .out_ready(out_ready), .result(result), .in_flight(in_flight)
  );

  compressor_tree_pipe #(.NUM_ELEMENTS(2), .BIT_LEN(8)) dut_small (
    .clk(clk), .rst(rst), .in_valid(s_in_valid), .in_ready(s_in_ready), .terms(s_terms),
    .out_valid(s_out_valid), .out_ready(s_out_ready), .result(s_result), .in_flight(s_in_flight)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic word_t ref_sum(input word_t v [N]);
    word_t s;
    s = '0;
    for (int i = 0; i < N; i++) s = s + v[i];
    return s;
  endfunction

  task automatic send(input word_t v [N], input word_t exp_val, input bit lat);
    int n;
    bit done;
    n = 0;
    done = 1'b0;
    while (!done) begin
      @(negedge clk);
      terms    = v;
      in_valid = 1'b1;
      #1;
      if (in_ready) begin
        sb.push_back('{val: exp_val, cyc: cyc, lat: lat});
        done = 1'b1;
      end else if (++n > 50) begin
        checks++;
        errors++;
        $display("FAIL send_timeout in_ready stuck at 0, required 1");
        done = 1'b1;
      end
    end
  endtask

  task automatic idle(input int c);
    repeat (c) begin
      @(negedge clk);
      in_valid = 1'b0;
    end
  endtask

  // Main monitor: pops on each output transfer, checks hold-while-stalled and latency.
  bit    prev_stall = 1'b0;
  word_t prev_res;
  always begin
    exp_t e;
    @(negedge clk);
    #2;
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("stall_valid", 64'(out_valid), 64'(1));
        check("stall_hold", 64'(result), 64'(prev_res));
      end
      if (out_valid) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL spurious_out result=%0h required no output", result);
        end else begin
          if (!prev_stall && sb[0].lat)
            check("latency", 64'(cyc - sb[0].cyc), 64'(L));
          if (out_ready) begin
            e = sb.pop_front();
            check("result", 64'(result), 64'(e.val));
          end
        end
      end
      prev_stall = out_valid & ~out_ready;
      prev_res   = result;
    end
  end

  // Monitor for the two-term instance (out_ready tied high).
  always begin
    sexp_t e;
    @(negedge clk);
    #2;
    if (!rst && s_out_valid) begin
      if (s_sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL small_spurious result=%0h required no output", s_result);
      end else begin
        e = s_sb.pop_front();
        check("small_result", 64'(s_result), 64'(e.val));
        check("small_latency", 64'(cyc - e.cyc), 64'(1));
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    word_t v [N];
    word_t set_a [N];
    word_t set_b [N];
    word_t set_c [N];
    word_t set_d [N];
    logic [63:0] r64;
    int wait_n;

    rst         = 1'b1;
    in_valid    = 1'b0;
    s_in_valid  = 1'b0;
    s_out_ready = 1'b1;
    s_terms[0]  = '0;
    s_terms[1]  = '0;
    for (int i = 0; i < N; i++) terms[i] = '0;

    // Reset state
    repeat (3) @(negedge clk);
    #1;
    check("reset_out_valid", 64'(out_valid), 64'(0));
    check("reset_in_flight", 64'(in_flight), 64'(0));
    @(negedge clk);
    #3;
    rst = 1'b0;
    #1;
    check("reset_in_ready", 64'(in_ready), 64'(1));

    // terms[i] = i+1 -> 231, three-cycle latency
    for (int i = 0; i < N; i++) v[i] = word_t'(i + 1);
    send(v, 58'd231, 1'b1);
    idle(6);
    check("idle_in_flight", 64'(in_flight), 64'(0));

    // All ones -> 2^58 - 21
    for (int i = 0; i < N; i++) v[i] = '1;
    send(v, 58'h3FF_FFFF_FFFF_FFEB, 1'b1);
    idle(6);

    // Back-to-back A..D with out_ready low, then drain in order
    for (int i = 0; i < N; i++) begin
      set_a[i] = word_t'(1000 + i);
      set_b[i] = word_t'(i * i * 7);
      set_c[i] = (i % 2 == 0) ? 58'h2AA_AAAA_AAAA_AAAA : 58'h155_5555_5555_5555;
      set_d[i] = word_t'(58'h100_0000_0000_0000) + word_t'(i);
    end
    mode = 2;
    idle(2);
    send(set_a, ref_sum(set_a), 1'b0);
    send(set_b, ref_sum(set_b), 1'b0);
    send(set_c, ref_sum(set_c), 1'b0);
    @(negedge clk);
    terms    = set_d;
    in_valid = 1'b1;
    #1;
    check("full_in_ready", 64'(in_ready), 64'(0));
    check("full_in_flight", 64'(in_flight), 64'(3));
    mode = 0;
    send(set_d, ref_sum(set_d), 1'b0);
    idle(8);

    // out_ready toggling, in_valid continuously high, 100 random sets
    mode = 1;
    for (int k = 0; k < 100; k++) begin
      for (int i = 0; i < N; i++) begin
        r64  = {$urandom, $urandom};
        v[i] = r64[W-1:0];
      end
      send(v, ref_sum(v), 1'b0);
    end
    idle(1);
    mode = 0;
    idle(12);

    // Reset with two sets in flight discards them
    mode = 2;
    idle(2);
    for (int i = 0; i < N; i++) v[i] = word_t'(3 * i + 11);
    send(v, ref_sum(v), 1'b0);
    send(v, ref_sum(v), 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    check("pre_reset_in_flight", 64'(in_flight), 64'(2));
    #2;
    rst = 1'b1;
    #1;
    check("rst_out_valid", 64'(out_valid), 64'(0));
    check("rst_in_flight", 64'(in_flight), 64'(0));
    sb.delete();
    @(negedge clk);
    #3;
    rst = 1'b0;
    #1;
    check("post_rst_in_ready", 64'(in_ready), 64'(1));
    mode = 0;
    for (int i = 0; i < N; i++) v[i] = word_t'(i + 1);
    send(v, 58'd231, 1'b1);
    idle(6);

    // Two-term instance: 5 + 7 = 12 after one cycle
    @(negedge clk);
    s_terms[0] = 8'd5;
    s_terms[1] = 8'd7;
    s_in_valid = 1'b1;
    #1;
    check("small_in_ready", 64'(s_in_ready), 64'(1));
    if (s_in_ready) s_sb.push_back('{val: 8'd12, cyc: cyc});
    @(negedge clk);
    s_in_valid = 1'b0;

    // Drain with a bounded wait
    wait_n = 0;
    while ((sb.size() != 0 || s_sb.size() != 0) && wait_n < 200) begin
      @(negedge clk);
      wait_n++;
    end
    checks++;
    if (sb.size() != 0 || s_sb.size() != 0) begin
      errors++;
      $display("FAIL drain outstanding=%0d required 0", sb.size() + s_sb.size());
    end
    idle(2);
    check("final_in_flight", 64'(in_flight), 64'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
